reg_wb_arbiter: RTL and testbench
=================================

REG_WB_ARBITER -- requirements
Module: reg_wb_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 2, load-writeback holding buffer entries (2..4).
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, consecutive ALU-won cycles with the buffer non-empty before a forced drain (1..15).
REQ-003 SHALL have ports: clk input 1, the single clock; rst_n input 1, asynchronous active-low reset.
REQ-004 SHALL have ports: alu_valid input 1, ALU writeback request; alu_rd input 5, ALU destination; alu_data input `XLEN, ALU result; alu_stall output 1, ALU request not accepted this cycle.
REQ-005 SHALL have ports: ld_valid input 1, load writeback request; ld_rd input 5, load destination; ld_data input `XLEN, load data; ld_ready output 1, load accepted when ld_valid and ld_ready are both high.
REQ-006 SHALL have ports: wr_en output 1, wr_addr output 5, wr_data output `XLEN, register-file write port; bypass_rd output 5, bypass_res output `XLEN, forwarding copy of the write port.

Function
REQ-007 SHALL register all write-port outputs: a source granted in cycle N appears on wr_en/wr_addr/wr_data in cycle N+1.
REQ-008 SHALL drive bypass_rd = wr_addr and bypass_res = wr_data whenever wr_en=1, and bypass_rd=0 when wr_en=0.
REQ-009 SHALL, in state IDLE (buffer empty), grant ALU if alu_valid; else grant the load directly; with both valid, ALU SHALL be granted and the load pushed into the buffer.
REQ-010 SHALL, in state PEND (buffer non-empty), grant ALU if alu_valid and alu_stall=0; otherwise pop and grant the buffer head; accepted loads SHALL always be pushed, never granted directly.
REQ-011 SHALL count consecutive PEND cycles in which ALU wins; on reaching STARVE_LIMIT, it SHALL enter FORCE for exactly one cycle.
REQ-012 SHALL, in FORCE, pop and grant the buffer head, assert alu_stall=1 combinationally, and return to PEND (count>1) or IDLE (count=1) with the counter cleared.
REQ-013 SHALL drive alu_stall=0 in IDLE and PEND; the ALU holds its request while alu_stall=1.
REQ-014 SHALL drive ld_ready = (count < DEPTH), combinational from the registered count; push and pop in the same cycle SHALL leave count unchanged.
REQ-015 SHALL accept requests with rd=0 without writing, without buffering and without advancing the starvation counter.
REQ-016 SHALL drain the buffer in FIFO order, with wrap-around of the read and write pointers modulo DEPTH.
REQ-017 SHALL drive wr_en=0 in the next cycle when no source is granted.

Reset
REQ-018 SHALL, while rst_n=0, force wr_en=0, wr_addr=0, wr_data=0, count=0, pointers=0, starvation counter=0, state IDLE.
REQ-019 SHALL discard buffered entries on reset assertion mid-operation; ld_ready=1 and alu_stall=0 follow from reset state.
REQ-020 SHALL make the first grant visible on the write port no earlier than the second rising clk edge after rst_n deasserts.

Configuration
REQ-021 SHALL, with WB_WAW_KILL_EN defined, invalidate every buffered entry whose rd equals alu_rd when an ALU write with nonzero rd is granted; invalidated entries are popped without asserting wr_en and do not count as grants.
REQ-022 SHALL, without WB_WAW_KILL_EN, write all buffered entries unmodified; WAW ordering is the pipeline's responsibility.

Verification
REQ-023 Reset: hold rst_n=0 with alu_valid=1 -> wr_en=0, ld_ready=1, alu_stall=0 throughout.
REQ-024 Simultaneous requests: alu (x5,0x11) and ld (x6,0x22) in cycle 0 -> x5/0x11 written in cycle 1, x6/0x22 written in cycle 2.
REQ-025 Full: ALU valid every cycle (rd=x1) with 3 loads offered and DEPTH=2 -> ld_ready=0 after 2 pushes; the third load is held until the forced drain.
REQ-026 Starvation: buffer holds x7/0xAA with continuous ALU requests -> alu_stall=1 in the 5th cycle; x7/0xAA written in the following cycle.
REQ-027 WAW: buffered ld x9/0x1, then ALU x9/0x2 granted -> with WB_WAW_KILL_EN only 0x2 is written; without it, 0x2 then 0x1.
REQ-028 rd=0: ld (x0,0xFF) on an empty buffer -> wr_en stays 0 and count stays 0.

Source files
------------

// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter: arbitrates the ALU and load writebacks onto one register-file
// write port. Loads that lose to the ALU wait in a small FIFO. A starvation
// counter forces a one-cycle drain when the ALU keeps winning.
// Optional feature macro: WB_WAW_KILL_EN. When it is defined, an ALU write
// invalidates buffered loads that target the same register.
`ifndef XLEN
`define XLEN 32
`endif

module reg_wb_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  input  logic [4:0]        alu_rd,
  input  logic [`XLEN-1:0]  alu_data,
  output logic              alu_stall,
  input  logic              ld_valid,
  input  logic [4:0]        ld_rd,
  input  logic [`XLEN-1:0]  ld_data,
  output logic              ld_ready,
  output logic              wr_en,
  output logic [4:0]        wr_addr,
  output logic [`XLEN-1:0]  wr_data,
  output logic [4:0]        bypass_rd,
  output logic [`XLEN-1:0]  bypass_res
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [3:0]    LIMIT_C  = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, PEND, FORCE} state_t;

  state_t state_q, state_d;

  logic [4:0]       buf_rd   [DEPTH];
  logic [`XLEN-1:0] buf_data [DEPTH];
  logic [DEPTH-1:0] buf_vld;
  logic [DEPTH-1:0] kill_mask;
  logic [PW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic [3:0]       starve_q, starve_d;

  logic             ld_acc, alu_nz, ld_nz;
  logic             grant_alu, grant_ld, push, pop;
  logic             wr_en_d;
  logic [4:0]       wr_addr_d;
  logic [`XLEN-1:0] wr_data_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign ld_ready   = (count_q < DEPTH_C);
  assign ld_acc     = ld_valid && ld_ready;
  assign alu_nz     = (alu_rd != 5'd0);
  assign ld_nz      = (ld_rd != 5'd0);
  assign bypass_rd  = wr_en ? wr_addr : 5'd0;
  assign bypass_res = wr_data;

  // Mark buffered loads overwritten by a granted ALU write to the same rd
  always_comb begin
    kill_mask = '0;
`ifdef WB_WAW_KILL_EN
    for (int unsigned i = 0; i < DEPTH; i++) begin
      kill_mask[PW'(i)] = grant_alu && alu_nz && buf_vld[PW'(i)] &&
                          (buf_rd[PW'(i)] == alu_rd);
    end
`endif
  end

  // Grant selection, write-port staging, starvation tracking and next state
  always_comb begin
    state_d   = state_q;
    starve_d  = starve_q;
    grant_alu = 1'b0;
    grant_ld  = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    alu_stall = 1'b0;
    wr_en_d   = 1'b0;
    wr_addr_d = '0;
    wr_data_d = '0;

    unique case (state_q)
      IDLE: begin
        if (alu_valid) begin
          grant_alu = 1'b1;
          push      = ld_acc && ld_nz;
        end else begin
          grant_ld  = ld_acc;
        end
      end
      PEND: begin
        push = ld_acc && ld_nz;
        if (alu_valid) grant_alu = 1'b1;
        else           pop       = 1'b1;
      end
      FORCE: begin
        alu_stall = 1'b1;
        pop       = 1'b1;
        push      = ld_acc && ld_nz;
      end
      default: ;
    endcase

    if (grant_alu && alu_nz) begin
      wr_en_d   = 1'b1;
      wr_addr_d = alu_rd;
      wr_data_d = alu_data;
    end else if (grant_ld && ld_nz) begin
      wr_en_d   = 1'b1;
      wr_addr_d = ld_rd;
      wr_data_d = ld_data;
    end else if (pop && buf_vld[rd_ptr_q]) begin
      wr_en_d   = 1'b1;
      wr_addr_d = buf_rd[rd_ptr_q];
      wr_data_d = buf_data[rd_ptr_q];
    end

    count_d = count_q + CW'(push) - CW'(pop);

    // rd=0 ALU wins in PEND neither write nor advance the starvation count
    if (state_q == PEND && grant_alu) begin
      if (alu_nz) begin
        starve_d = starve_q + 4'd1;
        if (starve_d == LIMIT_C) state_d = FORCE;
      end
    end else begin
      starve_d = '0;
      state_d  = (count_d != '0) ? PEND : IDLE;
    end
  end

  // State, occupancy, pointers, entry-valid bits and the registered write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      starve_q <= '0;
      buf_vld  <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      buf_vld  <= buf_vld & ~kill_mask;
      if (push) begin
        buf_vld[wr_ptr_q] <= 1'b1;
        wr_ptr_q          <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      wr_en   <= wr_en_d;
      wr_addr <= wr_addr_d;
      wr_data <= wr_data_d;
    end
  end

  // Buffer payload; occupancy and valid bits gate every read, so no reset
  always_ff @(posedge clk) begin
    if (push) begin
      buf_rd[wr_ptr_q]   <= ld_rd;
      buf_data[wr_ptr_q] <= ld_data;
    end
  end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// tb_reg_wb_arbiter: directed scenarios plus randomized traffic for
// reg_wb_arbiter, checked against a queue-based reference model.
`ifndef XLEN
`define XLEN 32
`endif

module tb_reg_wb_arbiter;

  localparam int XLEN   = `XLEN;
  localparam int DEPTH  = 2;
  localparam int STARVE = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            alu_valid = 1'b0;
  logic [4:0]      alu_rd = '0;
  logic [XLEN-1:0] alu_data = '0;
  logic            alu_stall;
  logic            ld_valid = 1'b0;
  logic [4:0]      ld_rd = '0;
  logic [XLEN-1:0] ld_data = '0;
  logic            ld_ready;
  logic            wr_en;
  logic [4:0]      wr_addr;
  logic [XLEN-1:0] wr_data;
  logic [4:0]      bypass_rd;
  logic [XLEN-1:0] bypass_res;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: pending loads as a queue, plus starvation bookkeeping
  logic [4:0]      mq_rd[$];
  logic [XLEN-1:0] mq_d[$];
  bit              mq_v[$];
  int              starve = 0;
  bit              force_m = 1'b0;
  bit              e_en;
  logic [4:0]      e_addr;
  logic [XLEN-1:0] e_data;

  reg_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_stall(alu_stall),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .bypass_rd(bypass_rd), .bypass_res(bypass_res)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    mq_rd.delete(); mq_d.delete(); mq_v.delete();
    starve = 0; force_m = 1'b0;
  endtask

  // One arbitration cycle of the reference model, from the current inputs
  task automatic model_step(input bit av, input logic [4:0] ard, input logic [XLEN-1:0] ad,
                            input bit lv, input logic [4:0] lrd, input logic [XLEN-1:0] ldd);
    bit acc, direct;
    acc    = lv && (mq_rd.size() < DEPTH);
    direct = (mq_rd.size() == 0) && !av && lv;
    e_en = 1'b0; e_addr = '0; e_data = '0;
    if (force_m || (mq_rd.size() != 0 && !av)) begin
      if (mq_v[0]) begin e_en = 1'b1; e_addr = mq_rd[0]; e_data = mq_d[0]; end
      void'(mq_rd.pop_front()); void'(mq_d.pop_front()); void'(mq_v.pop_front());
      starve = 0; force_m = 1'b0;
    end else if (av) begin
      if (ard != 0) begin
        e_en = 1'b1; e_addr = ard; e_data = ad;
        if (mq_rd.size() != 0) begin
`ifdef WB_WAW_KILL_EN
          foreach (mq_rd[i]) if (mq_rd[i] == ard) mq_v[i] = 1'b0;
`endif
          starve++;
          if (starve == STARVE) force_m = 1'b1;
        end
      end
    end else if (direct && lrd != 0) begin
      e_en = 1'b1; e_addr = lrd; e_data = ldd;
    end
    if (acc && !direct && lrd != 0) begin
      mq_rd.push_back(lrd); mq_d.push_back(ldd); mq_v.push_back(1'b1);
    end
  endtask

  // Drive one cycle, check handshakes before the edge and the write port after it
  task automatic cycle(input bit av, input logic [4:0] ard, input logic [XLEN-1:0] ad,
                       input bit lv, input logic [4:0] lrd, input logic [XLEN-1:0] ldd);
    alu_valid = av; alu_rd = ard; alu_data = ad;
    ld_valid = lv; ld_rd = lrd; ld_data = ldd;
    #1;
    chk("ld_ready", ld_ready, (mq_rd.size() < DEPTH));
    chk("alu_stall", alu_stall, force_m);
    model_step(av, ard, ad, lv, lrd, ldd);
    @(posedge clk); #1;
    chk("wr_en", wr_en, e_en);
    if (e_en) begin
      chk("wr_addr", wr_addr, e_addr);
      chk("wr_data", wr_data, e_data);
      chk("bypass_rd", bypass_rd, e_addr);
      chk("bypass_res", bypass_res, e_data);
    end else begin
      chk("bypass_rd_idle", bypass_rd, 5'd0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
  endtask

  // Assert reset with the ALU requesting, hold it, then release with one quiet cycle
  task automatic do_reset(input int n);
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h5;
    rst_n = 1'b0;
    #1;
    chk("rst_wr_en", wr_en, 1'b0);
    chk("rst_ld_ready", ld_ready, 1'b1);
    chk("rst_alu_stall", alu_stall, 1'b0);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk("rst_wr_en", wr_en, 1'b0);
      chk("rst_ld_ready", ld_ready, 1'b1);
      chk("rst_alu_stall", alu_stall, 1'b0);
    end
    model_clear();
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
    rst_n = 1'b1;
    idle(1);
  endtask

  initial begin
    bit              hold, av, lv;
    logic [4:0]      ard, lrd;
    logic [XLEN-1:0] ad, ldd;
    int              loads_left;

    #1;
    do_reset(3);

    // Simultaneous ALU and load: ALU first, buffered load next cycle
    cycle(1'b1, 5'd5, 32'h11, 1'b1, 5'd6, 32'h22);
    chk("sim_first_addr", wr_addr, 5'd5);
    chk("sim_first_data", wr_data, 32'h11);
    idle(1);
    chk("sim_second_addr", wr_addr, 5'd6);
    chk("sim_second_data", wr_data, 32'h22);
    idle(1);

    // Full buffer: ALU x1 every cycle, three loads offered until accepted
    loads_left = 3;
    for (int c = 0; c < 12; c++) begin
      bit will_acc;
      will_acc = (loads_left > 0) && (mq_rd.size() < DEPTH);
      if (c == 2) chk("full_ld_ready", ld_ready, 1'b0);
      cycle(1'b1, 5'd1, 32'h100 + c, loads_left > 0, 5'(10 + 3 - loads_left),
            32'h200 + loads_left);
      if (will_acc) loads_left--;
    end
    idle(4);

    // Starvation: x7 buffered behind continuous ALU requests
    cycle(1'b1, 5'd3, 32'h33, 1'b1, 5'd7, 32'hAA);
    for (int c = 1; c <= 4; c++) cycle(1'b1, 5'd3, 32'h40 + c, 1'b0, 5'd0, '0);
    alu_valid = 1'b1; #1;
    chk("starve_stall_c5", alu_stall, 1'b1);
    cycle(1'b1, 5'd3, 32'h45, 1'b0, 5'd0, '0);
    chk("starve_drain_addr", wr_addr, 5'd7);
    chk("starve_drain_data", wr_data, 32'hAA);
    idle(3);

    // WAW on x9: buffered load 0x1 followed by ALU 0x2
    cycle(1'b1, 5'd3, 32'h3, 1'b1, 5'd9, 32'h1);
    cycle(1'b1, 5'd9, 32'h2, 1'b0, 5'd0, '0);
    chk("waw_alu_data", wr_data, 32'h2);
    idle(1);
`ifdef WB_WAW_KILL_EN
    chk("waw_killed", wr_en, 1'b0);
`else
    chk("waw_old_data", wr_data, 32'h1);
`endif
    idle(2);

    // rd=0 load on an empty buffer: no write, nothing buffered
    cycle(1'b0, 5'd0, '0, 1'b1, 5'd0, 32'hFF);
    chk("rd0_wr_en", wr_en, 1'b0);
    #1;
    chk("rd0_ld_ready", ld_ready, 1'b1);
    idle(2);

    // Mid-operation reset discards buffered loads
    cycle(1'b1, 5'd2, 32'h7, 1'b1, 5'd4, 32'h8);
    cycle(1'b1, 5'd2, 32'h9, 1'b1, 5'd5, 32'hA);
    do_reset(2);
    idle(3);

    // Randomized traffic; ALU holds its request across a stall cycle
    hold = 1'b0; ard = '0; ad = '0; av = 1'b0;
    for (int c = 0; c < 400; c++) begin
      bit stalled_now;
      if (c == 200) begin
        do_reset(1);
        hold = 1'b0;
      end
      stalled_now = force_m;
      if (!hold) begin
        av  = ($urandom_range(0, 9) < 6);
        ard = 5'($urandom_range(0, 3));
        ad  = $urandom;
      end
      lv  = ($urandom_range(0, 1) == 1);
      lrd = 5'($urandom_range(0, 3));
      ldd = $urandom;
      cycle(av, ard, ad, lv, lrd, ldd);
      hold = stalled_now && av;
    end
    idle(8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
